// File: rtl/psa_ram_arbiter.sv
// Sample-SRAM arbiter for PSA: Z80 indirect-port write queue versus the playback fetch engine.
// Fetch has priority; a starvation guard forces a queued host write after STARVE_N fetch grants.
`timescale 1ns/1ps
module psa_ram_arbiter #(
  parameter int unsigned ADDR_W   = 11,
  parameter logic [7:0]  IO_BASE  = 8'hA0,
  parameter int unsigned WR_PULSE = 2,
  parameter int unsigned Q_DEPTH  = 2,
  parameter int unsigned STARVE_N = 4
) (
  input  logic              i_CLK,
  input  logic              i_nRST,
  input  logic              i_nIORQ,
  input  logic              i_nWR,
  input  logic [7:0]        i_ZA,
  input  logic [7:0]        i_ZD,
  input  logic              i_FETCH_REQ,
  input  logic [ADDR_W-1:0] i_FA,
  input  logic [7:0]        i_CD,
  output logic              o_FETCH_ACK,
  output logic [7:0]        o_FETCH_DATA,
  output logic              o_nRAM_CS,
  output logic              o_nRAM_WR,
  output logic [ADDR_W-1:0] o_CA,
  output logic [7:0]        o_CD,
  output logic              o_OVF
);

  localparam int unsigned QPW = (Q_DEPTH > 1) ? $clog2(Q_DEPTH) : 1;
  localparam int unsigned QCW = $clog2(Q_DEPTH + 1);
  localparam int unsigned SCW = $clog2(STARVE_N + 1);
  localparam int unsigned PCW = 3;

  localparam logic [7:0]     PORT_LO  = IO_BASE;
  localparam logic [7:0]     PORT_HI  = IO_BASE + 8'd1;
  localparam logic [7:0]     PORT_DAT = IO_BASE + 8'd2;
  localparam logic [QCW-1:0] Q_FULL   = QCW'(Q_DEPTH);
  localparam logic [SCW-1:0] STARVE_Q = SCW'(STARVE_N);
  localparam logic [PCW-1:0] PULSE_LD = PCW'(WR_PULSE - 1);

  typedef enum logic [2:0] {
    ST_IDLE, ST_RD1, ST_RD2, ST_WSU, ST_WLO, ST_WHD, ST_GAP
  } state_e;

  state_e            state_q, state_d;
  logic [1:0]        iorq_sync_q, iorq_sync_d;
  logic [1:0]        wr_sync_q, wr_sync_d;
  logic              act_prev_q, act_prev_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [ADDR_W-1:0] q_addr_q [Q_DEPTH];
  logic [ADDR_W-1:0] q_addr_d [Q_DEPTH];
  logic [7:0]        q_data_q [Q_DEPTH];
  logic [7:0]        q_data_d [Q_DEPTH];
  logic [QPW-1:0]    q_wp_q, q_wp_d, q_rp_q, q_rp_d;
  logic [QCW-1:0]    q_cnt_q, q_cnt_d;
  logic [SCW-1:0]    starve_q, starve_d;
  logic [PCW-1:0]    pcnt_q, pcnt_d;
  logic [ADDR_W-1:0] ca_q, ca_d;
  logic [7:0]        cd_q, cd_d;
  logic              ncs_q, ncs_d, nwr_q, nwr_d, ack_q, ack_d, ovf_q, ovf_d;
  logic [7:0]        fdata_q, fdata_d;

  logic host_act, host_evt, dat_port, q_push, q_pop, q_full, q_nempty;

  function automatic logic [QPW-1:0] qp_inc(input logic [QPW-1:0] p);
    return (p == QPW'(Q_DEPTH - 1)) ? '0 : p + QPW'(1);
  endfunction

  // Fetch handshake: i_FETCH_REQ is a level held with i_FA stable until the
  // one-cycle o_FETCH_ACK; the requester must drop it during the GAP cycle.
  always_comb begin
    iorq_sync_d = {iorq_sync_q[0], i_nIORQ};
    wr_sync_d   = {wr_sync_q[0], i_nWR};
    host_act    = ~(iorq_sync_q[1] | wr_sync_q[1]);
    host_evt    = host_act & ~act_prev_q;
    act_prev_d  = host_act;

    q_nempty = (q_cnt_q != '0);
    q_full   = (q_cnt_q == Q_FULL);
    q_pop    = (state_q == ST_WHD);
    dat_port = host_evt && (i_ZA == PORT_DAT);
    q_push   = dat_port && (!q_full || q_pop);

    ptr_d = ptr_q;
    ovf_d = ovf_q;
    if (host_evt && (i_ZA == PORT_LO)) ptr_d[7:0] = i_ZD;
    if (host_evt && (i_ZA == PORT_HI)) ptr_d[ADDR_W-1:8] = i_ZD[ADDR_W-9:0];
    // A dropped byte still consumes an address so the host stream stays aligned.
    if (dat_port) begin
      ptr_d = ptr_q + ADDR_W'(1);
      if (!q_push) ovf_d = 1'b1;
    end

    q_addr_d = q_addr_q;
    q_data_d = q_data_q;
    q_wp_d   = q_wp_q;
    q_rp_d   = q_rp_q;
    q_cnt_d  = q_cnt_q;
    if (q_push) begin
      q_addr_d[q_wp_q] = ptr_q;
      q_data_d[q_wp_q] = i_ZD;
      q_wp_d           = qp_inc(q_wp_q);
    end
    if (q_pop) q_rp_d = qp_inc(q_rp_q);
    case ({q_push, q_pop})
      2'b10:   q_cnt_d = q_cnt_q + QCW'(1);
      2'b01:   q_cnt_d = q_cnt_q - QCW'(1);
      default: q_cnt_d = q_cnt_q;
    endcase

    state_d  = state_q;
    starve_d = starve_q;
    pcnt_d   = pcnt_q;
    ca_d     = ca_q;
    cd_d     = cd_q;
    ncs_d    = ncs_q;
    nwr_d    = nwr_q;
    ack_d    = 1'b0;
    fdata_d  = fdata_q;

    case (state_q)
      ST_IDLE: begin
        if (q_nempty && (!i_FETCH_REQ || (starve_q == STARVE_Q))) begin
          state_d  = ST_WSU;
          ncs_d    = 1'b0;
          ca_d     = q_addr_q[q_rp_q];
          cd_d     = q_data_q[q_rp_q];
          starve_d = '0;
        end else if (i_FETCH_REQ) begin
          state_d = ST_RD1;
          ncs_d   = 1'b0;
          ca_d    = i_FA;
          if (q_nempty) starve_d = starve_q + SCW'(1);
        end
      end
      ST_RD1: state_d = ST_RD2;
      ST_RD2: begin
        state_d = ST_GAP;
        ncs_d   = 1'b1;
        fdata_d = i_CD;
        ack_d   = 1'b1;
      end
      ST_WSU: begin
        state_d = ST_WLO;
        nwr_d   = 1'b0;
        pcnt_d  = PULSE_LD;
      end
      ST_WLO: begin
        if (pcnt_q == '0) begin
          state_d = ST_WHD;
          nwr_d   = 1'b1;
        end else begin
          pcnt_d = pcnt_q - PCW'(1);
        end
      end
      ST_WHD: begin
        state_d = ST_GAP;
        ncs_d   = 1'b1;
      end
      ST_GAP:  state_d = ST_IDLE;
      default: begin
        state_d = ST_IDLE;
        ncs_d   = 1'b1;
        nwr_d   = 1'b1;
      end
    endcase

    if (!q_nempty) starve_d = '0;
  end

  always_ff @(posedge i_CLK or negedge i_nRST) begin
    if (!i_nRST) begin
      state_q     <= ST_IDLE;
      iorq_sync_q <= 2'b11;
      wr_sync_q   <= 2'b11;
      act_prev_q  <= 1'b0;
      ptr_q       <= '0;
      q_addr_q    <= '{default: '0};
      q_data_q    <= '{default: '0};
      q_wp_q      <= '0;
      q_rp_q      <= '0;
      q_cnt_q     <= '0;
      starve_q    <= '0;
      pcnt_q      <= '0;
      ca_q        <= '0;
      cd_q        <= '0;
      ncs_q       <= 1'b1;
      nwr_q       <= 1'b1;
      ack_q       <= 1'b0;
      fdata_q     <= '0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      iorq_sync_q <= iorq_sync_d;
      wr_sync_q   <= wr_sync_d;
      act_prev_q  <= act_prev_d;
      ptr_q       <= ptr_d;
      q_addr_q    <= q_addr_d;
      q_data_q    <= q_data_d;
      q_wp_q      <= q_wp_d;
      q_rp_q      <= q_rp_d;
      q_cnt_q     <= q_cnt_d;
      starve_q    <= starve_d;
      pcnt_q      <= pcnt_d;
      ca_q        <= ca_d;
      cd_q        <= cd_d;
      ncs_q       <= ncs_d;
      nwr_q       <= nwr_d;
      ack_q       <= ack_d;
      fdata_q     <= fdata_d;
      ovf_q       <= ovf_d;
    end
  end

  assign o_FETCH_ACK  = ack_q;
  assign o_FETCH_DATA = fdata_q;
  assign o_nRAM_CS    = ncs_q;
  assign o_nRAM_WR    = nwr_q;
  assign o_CA         = ca_q;
  assign o_CD         = cd_q;
  assign o_OVF        = ovf_q;

endmodule

// File: tb/tb_psa_ram_arbiter.sv
// Bench for psa_ram_arbiter: directed scenarios plus randomized host loads and fetches
// checked against a reference pointer/queue/memory model kept in the bench.
`timescale 1ns/1ps
module tb_psa_ram_arbiter;
  localparam int ADDR_W   = 11;
  localparam int WR_PULSE = 2;
  localparam int STARVE_N = 4;
  localparam logic [7:0] P_LO  = 8'hA0;
  localparam logic [7:0] P_HI  = 8'hA1;
  localparam logic [7:0] P_DAT = 8'hA2;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic              n_iorq = 1'b1, n_wr = 1'b1;
  logic [7:0]        za = '0, zd = '0;
  logic              fetch_req = 1'b0;
  logic [ADDR_W-1:0] fa = '0;
  logic [7:0]        i_cd;
  logic              o_fetch_ack, o_nram_cs, o_nram_wr, o_ovf;
  logic [7:0]        o_fetch_data, o_cd;
  logic [ADDR_W-1:0] o_ca;

  logic [7:0] phys_mem [2048];
  logic [7:0] ref_mem  [2048];
  logic       cd_ovr_en = 1'b0;
  logic [7:0] cd_ovr = '0;
  assign i_cd = cd_ovr_en ? cd_ovr : phys_mem[o_ca];

  psa_ram_arbiter #(.ADDR_W(ADDR_W), .IO_BASE(8'hA0), .WR_PULSE(WR_PULSE),
                    .Q_DEPTH(2), .STARVE_N(STARVE_N)) dut (
    .i_CLK(clk), .i_nRST(rst_n), .i_nIORQ(n_iorq), .i_nWR(n_wr), .i_ZA(za), .i_ZD(zd),
    .i_FETCH_REQ(fetch_req), .i_FA(fa), .i_CD(i_cd),
    .o_FETCH_ACK(o_fetch_ack), .o_FETCH_DATA(o_fetch_data), .o_nRAM_CS(o_nram_cs),
    .o_nRAM_WR(o_nram_wr), .o_CA(o_ca), .o_CD(o_cd), .o_OVF(o_ovf)
  );

  // scoreboard state
  logic [ADDR_W+7:0] exp_q[$];
  logic [ADDR_W-1:0] m_ptr = '0;
  int checks = 0;
  int errors = 0;
  int writes_done = 0;
  int ack_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit addr_pending(input logic [ADDR_W-1:0] a);
    for (int i = 0; i < exp_q.size(); i++)
      if (exp_q[i][ADDR_W+7:8] == a) return 1'b1;
    return 1'b0;
  endfunction

  // driver: one Z80 OUT cycle, called at a falling clock edge; model updated first
  task automatic z80_out(input logic [7:0] a, input logic [7:0] d, input bit drop);
    if (a == P_LO) m_ptr[7:0] = d;
    else if (a == P_HI) m_ptr[10:8] = d[2:0];
    else if (a == P_DAT) begin
      if (!drop) exp_q.push_back({m_ptr, d});
      m_ptr = m_ptr + 11'd1;
    end
    za = a; zd = d; n_iorq = 1'b0; n_wr = 1'b0;
    repeat (3) @(negedge clk);
    n_iorq = 1'b1; n_wr = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_ack(input string tag, input int max);
    int n;
    n = 0;
    do begin @(negedge clk); n++; end while (o_fetch_ack !== 1'b1 && n < max);
    chk(tag, o_fetch_ack, 1'b1);
  endtask

  task automatic do_fetch(input logic [ADDR_W-1:0] a);
    fa = a; fetch_req = 1'b1;
    wait_ack("fetch_ack_timeout", 40);
    fetch_req = 1'b0;
  endtask

  task automatic wait_drain(input int max);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < max) begin @(negedge clk); n++; end
    chk("drain_pending", exp_q.size(), 0);
    repeat (3) @(negedge clk);
  endtask

  // monitor: SRAM write timing, write scoreboard, fetch data, invariants
  initial begin
    logic [ADDR_W-1:0] lat_ca;
    logic [7:0]        lat_cd;
    logic [ADDR_W+7:0] e;
    int                low_cnt;
    bit                in_low;
    for (int i = 0; i < 2048; i++) begin
      phys_mem[i] = 8'($urandom_range(0, 255));
      ref_mem[i]  = phys_mem[i];
    end
    in_low = 1'b0; low_cnt = 0; lat_ca = '0; lat_cd = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        in_low = 1'b0; low_cnt = 0;
      end else begin
        if (o_nram_wr === 1'b0) begin
          chk("wr_without_cs", o_nram_cs, 1'b0);
          if (!in_low) begin
            in_low = 1'b1; low_cnt = 1; lat_ca = o_ca; lat_cd = o_cd;
          end else begin
            low_cnt++;
            chk("ca_stable_in_wlo", o_ca, lat_ca);
            chk("cd_stable_in_wlo", o_cd, lat_cd);
          end
        end else if (in_low) begin
          in_low = 1'b0;
          chk("wr_pulse_len", low_cnt, WR_PULSE);
          checks++;
          assert (exp_q.size() != 0) else begin
            errors++;
            $error("FAIL unexpected_write observed=%0h:%0h expected=none", lat_ca, lat_cd);
          end
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("wr_addr", lat_ca, e[ADDR_W+7:8]);
            chk("wr_data", lat_cd, e[7:0]);
            ref_mem[e[ADDR_W+7:8]] = e[7:0];
          end
          phys_mem[lat_ca] = lat_cd;
          writes_done++;
        end
        if (o_fetch_ack === 1'b1) begin
          ack_cnt++;
          chk("fetch_data", o_fetch_data, cd_ovr_en ? cd_ovr : ref_mem[fa]);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout");
    $fatal(1, "global timeout");
  end

  // stimulus
  initial begin
    int n, base, ack_base;
    logic [ADDR_W-1:0] ra, rb;
    int nw;

    // T1 reset held while inputs toggle
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      n_iorq = i[0]; n_wr = i[1]; za = P_DAT; zd = 8'($urandom_range(0, 255));
      fetch_req = i[0]; fa = 11'($urandom_range(0, 2047));
      chk("rst_cs", o_nram_cs, 1'b1);
      chk("rst_wr", o_nram_wr, 1'b1);
      chk("rst_ca", o_ca, 0);
      chk("rst_cd", o_cd, 0);
      chk("rst_ack", o_fetch_ack, 1'b0);
      chk("rst_fdata", o_fetch_data, 0);
      chk("rst_ovf", o_ovf, 1'b0);
    end
    n_iorq = 1'b1; n_wr = 1'b1; fetch_req = 1'b0; za = '0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("post_rst_cs", o_nram_cs, 1'b1);
    chk("post_rst_wr", o_nram_wr, 1'b1);
    chk("post_rst_ack", o_fetch_ack, 1'b0);
    chk("post_rst_writes", writes_done, 0);

    // T2 host load with pointer wrap
    z80_out(P_LO, 8'hFF, 1'b0);
    z80_out(P_HI, 8'h07, 1'b0);
    z80_out(P_DAT, 8'h5A, 1'b0);
    z80_out(P_DAT, 8'hA5, 1'b0);
    wait_drain(100);
    chk("t2_writes", writes_done, 2);
    chk("t2_ref_7ff", ref_mem[11'h7FF], 8'h5A);
    chk("t2_ref_000", ref_mem[11'h000], 8'hA5);

    // T3 fetch latency and data
    fa = 11'h123; cd_ovr = 8'h3C; cd_ovr_en = 1'b1; fetch_req = 1'b1;
    @(negedge clk);
    chk("t3_c1_ca", o_ca, 11'h123);
    chk("t3_c1_cs", o_nram_cs, 1'b0);
    chk("t3_c1_ack", o_fetch_ack, 1'b0);
    @(negedge clk);
    chk("t3_c2_cs", o_nram_cs, 1'b0);
    chk("t3_c2_ack", o_fetch_ack, 1'b0);
    @(negedge clk);
    chk("t3_c3_ack", o_fetch_ack, 1'b1);
    chk("t3_c3_data", o_fetch_data, 8'h3C);
    chk("t3_c3_cs", o_nram_cs, 1'b1);
    fetch_req = 1'b0;
    @(negedge clk);
    cd_ovr_en = 1'b0;
    chk("t3_ack_pulse", o_fetch_ack, 1'b0);
    chk("t3_data_held", o_fetch_data, 8'h3C);
    chk("t4_ovf_before", o_ovf, 1'b0);

    // T4 overflow under continuous fetch
    z80_out(P_LO, 8'h00, 1'b0);
    z80_out(P_HI, 8'h02, 1'b0);
    fa = 11'h155; fetch_req = 1'b1;
    z80_out(P_DAT, 8'h11, 1'b0);
    z80_out(P_DAT, 8'h22, 1'b0);
    z80_out(P_DAT, 8'h33, 1'b1);
    chk("t4_ovf_set", o_ovf, 1'b1);
    wait_ack("t4_ack_timeout", 40);
    fetch_req = 1'b0;
    wait_drain(200);
    z80_out(P_DAT, 8'h44, 1'b0);
    wait_drain(100);
    chk("t4_ref_200", ref_mem[11'h200], 8'h11);
    chk("t4_ref_203", ref_mem[11'h203], 8'h44);
    chk("t4_ovf_sticky", o_ovf, 1'b1);

    // T5 starvation guard
    z80_out(P_LO, 8'h00, 1'b0);
    z80_out(P_HI, 8'h03, 1'b0);
    fa = 11'h155; fetch_req = 1'b1;
    wait_ack("t5_first_ack", 40);
    n = 0;
    do begin @(negedge clk); n++; end while (o_nram_cs !== 1'b0 && n < 10);
    chk("t5_read_start", o_nram_cs, 1'b0);
    ack_base = ack_cnt;
    z80_out(P_DAT, 8'hC3, 1'b0);
    n = 0;
    while (o_nram_wr !== 1'b0 && n < 100) begin @(negedge clk); n++; end
    chk("t5_write_forced", o_nram_wr, 1'b0);
    // the read already in flight when the byte was posted is excluded
    chk("t5_starve_acks", ack_cnt - ack_base - 1, STARVE_N);
    wait_ack("t5_fetch_resumes", 40);
    fetch_req = 1'b0;
    wait_drain(100);
    chk("t5_ref_300", ref_mem[11'h300], 8'hC3);

    // T6 reset during write low phase
    z80_out(P_LO, 8'h40, 1'b0);
    z80_out(P_HI, 8'h05, 1'b0);
    za = P_DAT; zd = 8'h77; n_iorq = 1'b0; n_wr = 1'b0;
    n = 0;
    while (o_nram_wr !== 1'b0 && n < 30) begin @(negedge clk); n++; end
    chk("t6_wlo_reached", o_nram_wr, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_wr_abort", o_nram_wr, 1'b1);
    chk("t6_cs_abort", o_nram_cs, 1'b1);
    chk("t6_ovf_clear", o_ovf, 1'b0);
    n_iorq = 1'b1; n_wr = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1; m_ptr = '0;
    base = writes_done;
    repeat (20) @(negedge clk);
    chk("t6_no_write", writes_done, base);
    chk("t6_idle_cs", o_nram_cs, 1'b1);
    chk("t6_ref_540", ref_mem[11'h540], phys_mem[11'h540]);

    // randomized host loads with interleaved and read-back fetches
    for (int it = 0; it < 12; it++) begin
      ra = 11'($urandom_range(0, 2047));
      z80_out(P_LO, ra[7:0], 1'b0);
      z80_out(P_HI, {5'd0, ra[10:8]}, 1'b0);
      nw = $urandom_range(0, 2);
      for (int k = 0; k < nw; k++) z80_out(P_DAT, 8'($urandom_range(0, 255)), 1'b0);
      if ($urandom_range(0, 1) == 1) begin
        do rb = 11'($urandom_range(0, 2047)); while (addr_pending(rb));
        do_fetch(rb);
      end
      wait_drain(200);
      do_fetch(ra);
      repeat (2) @(negedge clk);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
